// File: rtl/clock_pkg.sv
// Shared encodings, default timing and strobe helpers for the clock/alarm set controller.
package clock_pkg;

  localparam logic [1:0] MODE_NORMAL    = 2'd0;
  localparam logic [1:0] MODE_SET_ALARM = 2'd1;
  localparam logic [1:0] MODE_SET_TIME  = 2'd2;

  localparam logic FIELD_HOUR = 1'b0;
  localparam logic FIELD_MIN  = 1'b1;

  localparam int unsigned DEF_DEB_MS       = 20;
  localparam int unsigned DEF_RPT_DELAY_MS = 500;
  localparam int unsigned DEF_RPT_RATE_MS  = 100;
  localparam int unsigned DEF_IDLE_MS      = 10000;
  localparam int unsigned DEF_CNT_W        = 16;

  typedef struct packed {
    logic t_hour;
    logic t_min;
    logic a_hour;
    logic a_min;
    logic clr_sec;
    logic alarm_stop;
  } strobe_t;

  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      MODE_NORMAL:    return MODE_SET_ALARM;
      MODE_SET_ALARM: return MODE_SET_TIME;
      default:        return MODE_NORMAL;
    endcase
  endfunction

  // Selects the single increment strobe addressed by the current mode and field.
  function automatic strobe_t inc_strobe(input logic [1:0] m, input logic f);
    strobe_t s;
    s = '0;
    if (m == MODE_SET_ALARM) begin
      s.a_hour = (f == FIELD_HOUR);
      s.a_min  = (f == FIELD_MIN);
    end else if (m == MODE_SET_TIME) begin
      s.t_hour = (f == FIELD_HOUR);
      s.t_min  = (f == FIELD_MIN);
    end
    return s;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Front-panel keys, ms tick and datapath control strobes of the set controller.
interface clock_set_ctrl_if;
  logic       tick_ms;
  logic       key_mode;
  logic       key_change;
  logic       key_turn;
  logic [1:0] mode;
  logic       ld_hour;
  logic       ld_min;
  logic       inc_t_hour;
  logic       inc_t_min;
  logic       inc_a_hour;
  logic       inc_a_min;
  logic       clr_sec;
  logic       alarm_stop;

  modport master (
    output tick_ms, key_mode, key_change, key_turn,
    input  mode, ld_hour, ld_min, inc_t_hour, inc_t_min, inc_a_hour, inc_a_min,
    input  clr_sec, alarm_stop
  );

  modport slave (
    input  tick_ms, key_mode, key_change, key_turn,
    output mode, ld_hour, ld_min, inc_t_hour, inc_t_min, inc_a_hour, inc_a_min,
    output clr_sec, alarm_stop
  );
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer, ms-based debounce and rising-edge press detect for one raw key.
module key_debounce #(
  parameter int unsigned DEB_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_ms,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_BITS = $clog2(DEB_MS + 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEB_MS - 1);

  logic                sync1_q, sync2_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                flip;

  assign flip = tick_ms && (sync2_q != level) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      press   <= flip && sync2_q;
      if (sync2_q == level) begin
        cnt_q <= '0;
      end else if (flip) begin
        cnt_q <= '0;
        level <= sync2_q;
      end else if (tick_ms && (cnt_q != CNT_LAST)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/field sequencer: turns debounced key presses into one-clock datapath strobes.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DEB_MS       = DEF_DEB_MS,
  parameter int unsigned RPT_DELAY_MS = DEF_RPT_DELAY_MS,
  parameter int unsigned RPT_RATE_MS  = DEF_RPT_RATE_MS,
  parameter int unsigned IDLE_MS      = DEF_IDLE_MS,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input logic             clk,
  input logic             rst,
  clock_set_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(RPT_DELAY_MS - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RPT_RATE_MS - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_MS - 1);

  logic lvl_mode, lvl_turn, lvl_change;
  logic press_mode, press_turn, press_change;
  logic unused_lvl;

  key_debounce #(.DEB_MS(DEB_MS)) u_deb_mode (
    .clk(clk), .rst(rst), .tick_ms(bus.tick_ms), .raw(bus.key_mode),
    .level(lvl_mode), .press(press_mode)
  );
  key_debounce #(.DEB_MS(DEB_MS)) u_deb_turn (
    .clk(clk), .rst(rst), .tick_ms(bus.tick_ms), .raw(bus.key_turn),
    .level(lvl_turn), .press(press_turn)
  );
  key_debounce #(.DEB_MS(DEB_MS)) u_deb_change (
    .clk(clk), .rst(rst), .tick_ms(bus.tick_ms), .raw(bus.key_change),
    .level(lvl_change), .press(press_change)
  );

  assign unused_lvl = lvl_mode ^ lvl_turn;

  logic [1:0]       mode_q, mode_d;
  logic             field_q, field_d;
  logic             rpt_en_q, rpt_en_d;
  logic             rpt_first_q, rpt_first_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  strobe_t          stb_q, stb_d;
  logic             in_set, repeating;
  logic [CNT_W-1:0] rpt_last;

  assign in_set    = (mode_q != MODE_NORMAL);
  // rpt_en only arms on a change press inside a set mode, so a held key never repeats in NORMAL.
  assign repeating = in_set && rpt_en_q && lvl_change;
  assign rpt_last  = rpt_first_q ? DELAY_LAST : RATE_LAST;

  always_comb begin
    mode_d      = mode_q;
    field_d     = field_q;
    rpt_en_d    = rpt_en_q;
    rpt_first_d = rpt_first_q;
    rpt_cnt_d   = rpt_cnt_q;
    idle_d      = idle_q;
    stb_d       = '0;
    if (press_mode) begin
      mode_d   = next_mode(mode_q);
      field_d  = FIELD_HOUR;
      idle_d   = '0;
      rpt_en_d = 1'b0;
    end else if (press_turn) begin
      idle_d = '0;
      if (in_set) field_d = ~field_q;
      else        stb_d.clr_sec = 1'b1;
    end else if (press_change) begin
      idle_d = '0;
      if (in_set) begin
        stb_d       = inc_strobe(mode_q, field_q);
        rpt_en_d    = 1'b1;
        rpt_first_d = 1'b1;
        rpt_cnt_d   = '0;
      end else begin
        stb_d.alarm_stop = 1'b1;
      end
    end else begin
      if (!lvl_change || !in_set) rpt_en_d = 1'b0;
      if (repeating && bus.tick_ms) begin
        if (rpt_cnt_q >= rpt_last) begin
          stb_d       = inc_strobe(mode_q, field_q);
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      if (in_set && !repeating && bus.tick_ms) begin
        if (idle_q >= IDLE_LAST) begin
          mode_d   = MODE_NORMAL;
          field_d  = FIELD_HOUR;
          idle_d   = '0;
          rpt_en_d = 1'b0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= MODE_NORMAL;
      field_q     <= FIELD_HOUR;
      rpt_en_q    <= 1'b0;
      rpt_first_q <= 1'b0;
      rpt_cnt_q   <= '0;
      idle_q      <= '0;
      stb_q       <= '0;
    end else begin
      mode_q      <= mode_d;
      field_q     <= field_d;
      rpt_en_q    <= rpt_en_d;
      rpt_first_q <= rpt_first_d;
      rpt_cnt_q   <= rpt_cnt_d;
      idle_q      <= idle_d;
      stb_q       <= stb_d;
    end
  end

  assign bus.mode       = mode_q;
  assign bus.ld_hour    = in_set && (field_q == FIELD_HOUR);
  assign bus.ld_min     = in_set && (field_q == FIELD_MIN);
  assign bus.inc_t_hour = stb_q.t_hour;
  assign bus.inc_t_min  = stb_q.t_min;
  assign bus.inc_a_hour = stb_q.a_hour;
  assign bus.inc_a_min  = stb_q.a_min;
  assign bus.clr_sec    = stb_q.clr_sec;
  assign bus.alarm_stop = stb_q.alarm_stop;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scenario bench for clock_set_ctrl: ms tick every 2 clocks, keys driven with random timing.
module tb_clock_set_ctrl;

  localparam int DEB = 20;
  localparam int DLY = 500;
  localparam int RATE = 100;
  localparam int IDLE = 10000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  clock_set_ctrl_if bus ();

  clock_set_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    bus.tick_ms = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.tick_ms = ~bus.tick_ms;
    end
  end

  int cyc = 0;
  int n_t_hour = 0, n_t_min = 0, n_a_hour = 0, n_a_min = 0, n_clr = 0, n_stop = 0, n_multi = 0;
  int last_inc_cyc = 0, mode_chg_cyc = 0;
  logic [1:0] prev_mode = 2'd0;
  int th_q[$];
  int errors = 0, checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.inc_t_hour) begin n_t_hour <= n_t_hour + 1; th_q.push_back(cyc); end
    if (bus.inc_t_min) n_t_min <= n_t_min + 1;
    if (bus.inc_a_hour) n_a_hour <= n_a_hour + 1;
    if (bus.inc_a_min) n_a_min <= n_a_min + 1;
    if (bus.clr_sec) n_clr <= n_clr + 1;
    if (bus.alarm_stop) n_stop <= n_stop + 1;
    if (bus.inc_t_hour | bus.inc_t_min | bus.inc_a_hour | bus.inc_a_min) last_inc_cyc <= cyc;
    if ($countones({bus.inc_t_hour, bus.inc_t_min, bus.inc_a_hour, bus.inc_a_min,
                    bus.clr_sec, bus.alarm_stop}) > 1) n_multi <= n_multi + 1;
    if (bus.mode !== prev_mode) mode_chg_cyc <= cyc;
    prev_mode <= bus.mode;
  end

  function automatic int inc_total();
    return n_t_hour + n_t_min + n_a_hour + n_a_min;
  endfunction

  task automatic wait_ms(input int ms);
    repeat (2 * ms) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic set_key(input int which, input logic v);
    case (which)
      0: bus.key_mode = v;
      1: bus.key_turn = v;
      default: bus.key_change = v;
    endcase
  endtask

  // Hold a key, release it, then let the release debounce fully.
  task automatic tap(input int which, input int hold_ms);
    set_key(which, 1'b1);
    wait_ms(hold_ms);
    set_key(which, 1'b0);
    wait_ms(DEB + 20);
  endtask

  task automatic test_reset();
    bus.key_mode = 0; bus.key_turn = 0; bus.key_change = 0;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.mode, bus.ld_hour, bus.ld_min, bus.inc_t_hour, bus.inc_t_min, bus.inc_a_hour,
         bus.inc_a_min, bus.clr_sec, bus.alarm_stop} !== 11'd0) begin
      errors++; $display("FAIL reset_outputs: mode=%0d ld=%b%b (all must be 0)",
                         bus.mode, bus.ld_hour, bus.ld_min);
    end
    rst = 1'b0;
    wait_ms(5);
    checks++;
    if (bus.mode !== 2'd0 || bus.ld_hour !== 1'b0) begin
      errors++; $display("FAIL post_reset_mode: mode=%0d ld_hour=%b need 0/0", bus.mode, bus.ld_hour);
    end
  endtask

  task automatic test_glitch_and_mode();
    int g, t0, lat, k;
    g = int'($urandom_range(3, 12));
    tap(0, g);
    checks++;
    if (bus.mode !== 2'd0) begin
      errors++; $display("FAIL glitch_rejected: %0d ms pulse gave mode=%0d need 0", g, bus.mode);
    end
    bus.key_mode = 1'b1;
    t0 = cyc; k = 0;
    while (bus.mode !== 2'd1 && k < 200) begin @(negedge clk); k++; end
    lat = cyc - t0;
    checks++;
    if (bus.mode !== 2'd1) begin
      errors++; $display("FAIL mode_press: mode=%0d need 1", bus.mode);
    end
    checks++;
    if (lat < 2 * DEB || lat > 2 * DEB + 4) begin
      errors++; $display("FAIL press_latency: %0d clk need %0d..%0d", lat, 2 * DEB, 2 * DEB + 4);
    end
    wait_ms(5);
    bus.key_mode = 1'b0;
    wait_ms(DEB + 20);
    checks++;
    if (bus.ld_hour !== 1'b1 || bus.ld_min !== 1'b0) begin
      errors++; $display("FAIL set_alarm_field: ld=%b%b need 10", bus.ld_hour, bus.ld_min);
    end
  endtask

  task automatic test_field_inc();
    int am, tot;
    tap(1, int'($urandom_range(25, 50)));
    checks++;
    if (bus.ld_min !== 1'b1 || bus.ld_hour !== 1'b0) begin
      errors++; $display("FAIL turn_field: ld=%b%b need 01", bus.ld_hour, bus.ld_min);
    end
    am = n_a_min; tot = inc_total();
    tap(2, int'($urandom_range(25, 60)));
    checks++;
    if (n_a_min - am !== 1 || inc_total() - tot !== 1) begin
      errors++; $display("FAIL inc_a_min: a_min+%0d total+%0d need 1/1", n_a_min - am,
                         inc_total() - tot);
    end
    tap(0, int'($urandom_range(25, 50)));
    checks++;
    if (bus.mode !== 2'd2 || bus.ld_hour !== 1'b1) begin
      errors++; $display("FAIL set_time_entry: mode=%0d ld_hour=%b need 2/1", bus.mode, bus.ld_hour);
    end
  endtask

  task automatic test_repeat();
    int h, base, n, exp_n, other, d;
    for (int it = 0; it < 2; it++) begin
      h = (it == 0) ? 950 : 100 * int'($urandom_range(6, 12)) + int'($urandom_range(30, 70));
      exp_n = 1 + ((h > DLY) ? (h - DLY) / RATE + 1 : 0);
      base = th_q.size();
      other = n_t_min + n_a_hour + n_a_min;
      bus.key_change = 1'b1;
      wait_ms(h);
      bus.key_change = 1'b0;
      wait_ms(300);
      n = th_q.size() - base;
      checks++;
      if (n !== exp_n) begin
        errors++; $display("FAIL repeat_count[%0d ms]: %0d pulses need %0d", h, n, exp_n);
      end
      if (n >= 2) begin
        d = th_q[base + 1] - th_q[base];
        checks++;
        if (d < 2 * DLY - 2 || d > 2 * DLY + 2) begin
          errors++; $display("FAIL repeat_delay: %0d clk need %0d", d, 2 * DLY);
        end
      end
      if (n >= 3) begin
        d = th_q[base + 2] - th_q[base + 1];
        checks++;
        if (d < 2 * RATE - 2 || d > 2 * RATE + 2) begin
          errors++; $display("FAIL repeat_rate: %0d clk need %0d", d, 2 * RATE);
        end
      end
      checks++;
      if (n_t_min + n_a_hour + n_a_min !== other) begin
        errors++; $display("FAIL repeat_target: stray inc strobes %0d",
                           n_t_min + n_a_hour + n_a_min - other);
      end
    end
  endtask

  task automatic test_normal();
    int tot, c0, s0, nt;
    tap(0, 30);
    checks++;
    if (bus.mode !== 2'd0 || bus.ld_hour !== 1'b0 || bus.ld_min !== 1'b0) begin
      errors++; $display("FAIL back_to_normal: mode=%0d ld=%b%b need 0/00", bus.mode, bus.ld_hour,
                         bus.ld_min);
    end
    tot = inc_total(); c0 = n_clr; s0 = n_stop;
    nt = int'($urandom_range(1, 3));
    for (int i = 0; i < nt; i++) tap(1, int'($urandom_range(25, 50)));
    checks++;
    if (n_clr - c0 !== nt) begin
      errors++; $display("FAIL clr_sec: %0d strobes need %0d", n_clr - c0, nt);
    end
    tap(2, int'($urandom_range(25, 50)));
    checks++;
    if (n_stop - s0 !== 1) begin
      errors++; $display("FAIL alarm_stop_tap: %0d strobes need 1", n_stop - s0);
    end
    tap(2, 2000);
    checks++;
    if (n_stop - s0 !== 2) begin
      errors++; $display("FAIL alarm_stop_hold: %0d strobes need 2", n_stop - s0);
    end
    checks++;
    if (inc_total() !== tot) begin
      errors++; $display("FAIL normal_no_inc: %0d inc strobes need 0", inc_total() - tot);
    end
  endtask

  task automatic test_idle();
    int t, hold;
    tap(0, 30);
    t = mode_chg_cyc;
    wait_until(t + 2 * (IDLE - 10));
    checks++;
    if (bus.mode !== 2'd1) begin
      errors++; $display("FAIL idle_early: mode=%0d need 1", bus.mode);
    end
    wait_until(t + 2 * (IDLE + 10));
    checks++;
    if (bus.mode !== 2'd0 || bus.ld_hour !== 1'b0 || bus.ld_min !== 1'b0) begin
      errors++; $display("FAIL idle_timeout: mode=%0d ld=%b%b need 0/00", bus.mode, bus.ld_hour,
                         bus.ld_min);
    end
    tap(0, 30);
    t = mode_chg_cyc;
    hold = int'($urandom_range(25, 40));
    wait_until(t + 2 * (IDLE - 40));
    tap(2, hold);
    wait_until(t + 2 * (IDLE + 20));
    checks++;
    if (bus.mode !== 2'd1) begin
      errors++; $display("FAIL idle_restart: mode=%0d need 1", bus.mode);
    end
    t = last_inc_cyc;
    wait_until(t + 2 * (hold + IDLE - 15));
    checks++;
    if (bus.mode !== 2'd1) begin
      errors++; $display("FAIL idle_restart_early: mode=%0d need 1", bus.mode);
    end
    wait_until(t + 2 * (hold + IDLE + 15));
    checks++;
    if (bus.mode !== 2'd0) begin
      errors++; $display("FAIL idle_restart_timeout: mode=%0d need 0", bus.mode);
    end
  endtask

  task automatic test_coincident();
    int tot;
    tap(0, 30);
    tot = inc_total();
    bus.key_mode = 1'b1; bus.key_change = 1'b1;
    wait_ms(30);
    bus.key_mode = 1'b0;
    wait_ms(670);
    bus.key_change = 1'b0;
    wait_ms(DEB + 20);
    checks++;
    if (bus.mode !== 2'd2 || bus.ld_hour !== 1'b1) begin
      errors++; $display("FAIL coincident_mode: mode=%0d ld_hour=%b need 2/1", bus.mode, bus.ld_hour);
    end
    checks++;
    if (inc_total() !== tot) begin
      errors++; $display("FAIL coincident_no_inc: %0d inc strobes need 0", inc_total() - tot);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int tot;
    tot = inc_total();
    bus.key_change = 1'b1;
    wait_ms(int'($urandom_range(720, 880)));
    checks++;
    if (inc_total() - tot < 3) begin
      errors++; $display("FAIL pre_reset_repeat: %0d strobes need >=3", inc_total() - tot);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.mode, bus.ld_hour, bus.ld_min, bus.inc_t_hour, bus.inc_t_min, bus.inc_a_hour,
         bus.inc_a_min, bus.clr_sec, bus.alarm_stop} !== 11'd0) begin
      errors++; $display("FAIL async_reset: mode=%0d ld=%b%b inc_t_hour=%b need all 0", bus.mode,
                         bus.ld_hour, bus.ld_min, bus.inc_t_hour);
    end
    bus.key_change = 1'b0;
    @(negedge clk);
    tot = inc_total() + n_clr + n_stop;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ms(50);
    checks++;
    if (bus.mode !== 2'd0 || inc_total() + n_clr + n_stop !== tot) begin
      errors++; $display("FAIL after_reset: mode=%0d strobes=%0d need 0/0", bus.mode,
                         inc_total() + n_clr + n_stop - tot);
    end
  endtask

  task automatic test_strobe_exclusive();
    checks++;
    if (n_multi !== 0) begin
      errors++; $display("FAIL strobe_exclusive: %0d clk with >1 strobe need 0", n_multi);
    end
  endtask

  initial begin
    test_reset();
    test_glitch_and_mode();
    test_field_inc();
    test_repeat();
    test_normal();
    test_idle();
    test_coincident();
    test_reset_mid_repeat();
    test_strobe_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
